// File: rtl/clk_div_mc.sv
// Multi-channel programmable clock divider with a shared config port.
// Each channel runs a down-counter; new divisors apply at period starts.
module clk_div_mc #(
    parameter  int CH      = 4,
    parameter  int W       = 8,
    parameter  int DEF_DIV = 2,
    localparam int CW      = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clk_i,
    input  logic          rst_n,
    input  logic [CH-1:0] ch_en_i,
    input  logic          cfg_we_i,
    input  logic [CW-1:0] cfg_ch_i,
    input  logic [W-1:0]  cfg_div_i,
    input  logic          cfg_mode_i,
    input  logic          cfg_sync_i,
    output logic          cfg_ready_o,
    output logic          cfg_err_o,
    output logic [CH-1:0] div_clk_o,
    output logic [CH-1:0] div_tick_o
);

    localparam logic [W-1:0] ONE = W'(1);
    localparam logic [W-1:0] DEF = W'(DEF_DIV);

    logic [CH-1:0] pv;
    logic [CH-1:0] sel;
    logic          ch_ok;
    logic          div_ok;
    logic          accept;

    always_comb begin
        sel         = '0;
        cfg_ready_o = 1'b0;
        for (int c = 0; c < CH; c++) begin
            if (cfg_ch_i == CW'(c)) begin
                sel[c]      = 1'b1;
                cfg_ready_o = ~pv[c];
            end
        end
    end

    assign ch_ok  = |sel;
    assign div_ok = |cfg_div_i[W-1:1];
    assign accept = cfg_we_i & cfg_ready_o & div_ok;

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            cfg_err_o <= 1'b0;
        end else begin
            cfg_err_o <= cfg_we_i & (~ch_ok | ~div_ok);
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [W-1:0] div_q;
        logic [W-1:0] pdiv_q;
        logic [W-1:0] cnt_q;
        logic         mode_q;
        logic         pmode_q;
        logic         pv_q;
        logic         clk_q;
        logic         tick_q;

        logic         wr;
        logic         start;
        logic         take_wr;
        logic         take_pend;
        logic [W-1:0] div_n;
        logic [W-1:0] cnt_n;
        logic         mode_n;
        logic         pv_n;

        always_comb begin
            wr        = accept & sel[c];
            start     = ch_en_i[c] & (cfg_sync_i | (cnt_q == '0));
            // A write landing with sync is folded straight into the restart
            take_wr   = start & cfg_sync_i & wr;
            take_pend = pv_q & ~take_wr & (start | ~ch_en_i[c]);
            div_n     = div_q;
            mode_n    = mode_q;
            if (take_wr) begin
                div_n  = cfg_div_i;
                mode_n = cfg_mode_i;
            end else if (take_pend) begin
                div_n  = pdiv_q;
                mode_n = pmode_q;
            end
            pv_n  = (pv_q & ~take_pend) | (wr & ~take_wr);
            cnt_n = '0;
            if (ch_en_i[c]) begin
                cnt_n = start ? (div_n - ONE) : (cnt_q - ONE);
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_n) begin
                div_q   <= DEF;
                mode_q  <= 1'b0;
                pdiv_q  <= DEF;
                pmode_q <= 1'b0;
                pv_q    <= 1'b0;
                cnt_q   <= '0;
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                div_q  <= div_n;
                mode_q <= mode_n;
                pv_q   <= pv_n;
                cnt_q  <= cnt_n;
                if (wr & ~take_wr) begin
                    pdiv_q  <= cfg_div_i;
                    pmode_q <= cfg_mode_i;
                end
                tick_q <= start;
                clk_q  <= ch_en_i[c] &
                          (mode_n ? start : (cnt_n >= (div_n >> 1)));
            end
        end

        assign pv[c]         = pv_q;
        assign div_clk_o[c]  = clk_q;
        assign div_tick_o[c] = tick_q;
    end

endmodule
